// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial pattern detector: FSM states,
// history geometry and the pattern/overlap values restored by reset.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int HIST_W = 4;
    localparam int FILL_W = $clog2(HIST_W + 1);

    localparam logic [HIST_W-1:0] RST_PATTERN = 4'b1101;
    localparam logic              RST_OVERLAP = 1'b1;
    localparam logic [FILL_W-1:0] FILL_FULL   = FILL_W'(HIST_W);

endpackage

// File: rtl/seq_detect_ctrl_pattern_match.sv
// Bit history, fill counter and compare for the detector. hit_o is combinational
// and reflects the history as it will be after the current shift.
module pattern_match
    import seq_detect_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              shift_en_i,
    input  logic              bit_i,
    input  logic [HIST_W-1:0] pattern_i,
    input  logic              overlap_i,
    output logic              hit_o
);

    logic [HIST_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [HIST_W-1:0] shifted;
    logic [FILL_W-1:0] fill_inc;

    assign shifted  = {hist_q[HIST_W-2:0], bit_i};
    assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        hit_o  = 1'b0;
        if (clear_i) begin
            hist_d = '0;
            fill_d = '0;
        end else if (shift_en_i) begin
            hist_d = shifted;
            fill_d = fill_inc;
            if (fill_inc == FILL_FULL && shifted == pattern_i) begin
                hit_o = 1'b1;
                // Non-overlapping mode needs four fresh bits before the next hit.
                if (!overlap_i) begin
                    fill_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Frame controller for a 4-bit serial pattern detector (IDLE/RUN/DONE).
// Optional macro SEQDET_FIRST_HIT_EN adds first_hit/hit_seen outputs.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [HIST_W-1:0] cfg_pattern,
    input  logic              cfg_overlap,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic              abort,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    output logic              busy,
    output logic              match,
    output logic              done,
    output logic [CNT_W-1:0]  match_cnt
`ifdef SEQDET_FIRST_HIT_EN
    ,
    output logic [LEN_W-1:0]  first_hit,
    output logic              hit_seen
`endif
);

    state_t            state_q, state_d;
    logic [HIST_W-1:0] pattern_q, pattern_d;
    logic              overlap_q, overlap_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              match_q, match_d;
    logic              done_q, done_d;
    logic              accept;
    logic              clear;
    logic              hit;
`ifdef SEQDET_FIRST_HIT_EN
    logic [LEN_W-1:0]  first_hit_q, first_hit_d;
    logic              hit_seen_q, hit_seen_d;
`endif

    assign accept = (state_q == RUN) && bit_valid;

    pattern_match u_match (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (clear),
        .shift_en_i (accept),
        .bit_i      (bit_in),
        .pattern_i  (pattern_q),
        .overlap_i  (overlap_q),
        .hit_o      (hit)
    );

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        overlap_d = overlap_q;
        len_d     = len_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        match_d   = 1'b0;
        done_d    = 1'b0;
        clear     = 1'b0;
`ifdef SEQDET_FIRST_HIT_EN
        first_hit_d = first_hit_q;
        hit_seen_d  = hit_seen_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    pattern_d = cfg_pattern;
                    overlap_d = cfg_overlap;
                end
                if (start) begin
                    cnt_d = '0;
                    clear = 1'b1;
`ifdef SEQDET_FIRST_HIT_EN
                    first_hit_d = '0;
                    hit_seen_d  = 1'b0;
`endif
                    if (frame_len != '0) begin
                        len_d   = frame_len;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    idx_d = idx_q + LEN_W'(1);
                    if (hit) begin
                        match_d = 1'b1;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
`ifdef SEQDET_FIRST_HIT_EN
                        if (!hit_seen_q) begin
                            first_hit_d = idx_q;
                            hit_seen_d  = 1'b1;
                        end
`endif
                    end
                end
                // Abort wins over frame completion; a hit on that edge still counts.
                if (abort) begin
                    state_d = IDLE;
                end else if (accept && idx_q == len_q - LEN_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            pattern_q <= RST_PATTERN;
            overlap_q <= RST_OVERLAP;
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQDET_FIRST_HIT_EN
            first_hit_q <= '0;
            hit_seen_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            overlap_q <= overlap_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            done_q    <= done_d;
`ifdef SEQDET_FIRST_HIT_EN
            first_hit_q <= first_hit_d;
            hit_seen_q  <= hit_seen_d;
`endif
        end
    end

    assign bit_ready = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign match     = match_q;
    assign done      = done_q;
    assign match_cnt = cnt_q;
`ifdef SEQDET_FIRST_HIT_EN
    assign first_hit = first_hit_q;
    assign hit_seen  = hit_seen_q;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: a small reference model queues the
// expected match pulse per driven bit; frame totals are checked against constants.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [3:0] cfg_pattern = 4'b0000;
    logic       cfg_overlap = 1'b0;
    logic       start = 1'b0;
    logic [7:0] frame_len = 8'd0;
    logic       abort = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;

    logic       bit_ready, busy, match, done;
    logic [7:0] match_cnt;
    logic       bit_ready2, busy2, match2, done2;
    logic [1:0] match_cnt2;
`ifdef SEQDET_FIRST_HIT_EN
    logic [7:0] first_hit, first_hit2;
    logic       hit_seen, hit_seen2;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] m_hist;
    int         m_fill;
    logic [3:0] m_pat;
    logic       m_ovl;
    logic       exp_q[$];

    localparam logic [31:0] STREAM_A = 32'b0011_0101_1010;  // 12 bits
    localparam logic [31:0] STREAM_B = 32'b110_1101;        // 7 bits

    always #5 clk = ~clk;

    seq_detect_ctrl #(.LEN_W(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .start(start), .frame_len(frame_len),
        .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(bit_ready), .busy(busy), .match(match), .done(done),
        .match_cnt(match_cnt)
`ifdef SEQDET_FIRST_HIT_EN
        , .first_hit(first_hit), .hit_seen(hit_seen)
`endif
    );

    seq_detect_ctrl #(.LEN_W(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .start(start), .frame_len(frame_len),
        .abort(abort), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(bit_ready2), .busy(busy2), .match(match2), .done(done2),
        .match_cnt(match_cnt2)
`ifdef SEQDET_FIRST_HIT_EN
        , .first_hit(first_hit2), .hit_seen(hit_seen2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_shift(input logic b, output logic hit);
        m_hist = {m_hist[2:0], b};
        if (m_fill < 4) m_fill++;
        hit = 1'b0;
        if (m_fill == 4 && m_hist == m_pat) begin
            hit = 1'b1;
            if (!m_ovl) m_fill = 0;
        end
    endtask

    task automatic model_reset();
        m_hist = 4'b0000;
        m_fill = 0;
        m_pat  = 4'b1101;
        m_ovl  = 1'b1;
    endtask

    task automatic cfg(input logic [3:0] pat, input logic ovl);
        cfg_we = 1'b1; cfg_pattern = pat; cfg_overlap = ovl;
        tick();
        cfg_we = 1'b0;
        m_pat = pat; m_ovl = ovl;
    endtask

    task automatic start_frame(input logic [7:0] len);
        start = 1'b1; frame_len = len;
        tick();
        start = 1'b0;
        m_hist = 4'b0000; m_fill = 0;
        checks++;
        if (busy !== 1'b1 || bit_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_busy: got busy=%b ready=%b, expected 1/1", busy, bit_ready);
        end
        checks++;
        if (match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL start_cnt_clear: got %0d, expected 0", match_cnt);
        end
    endtask

    // Drives n bits of s (MSB first); mask bit i records a match pulse after bit i.
    task automatic send_bits(input logic [31:0] s, input int n, input bit gap,
                             output logic [31:0] mask);
        logic h, e;
        mask = '0;
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                bit_valid = 1'b0;
                tick();
                checks++;
                if (match !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_match: bit %0d got %b, expected 0", i, match);
                end
            end
            bit_valid = 1'b1;
            bit_in = s[n-1-i];
            model_shift(bit_in, h);
            exp_q.push_back(h);
            tick();
            bit_valid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if (match !== e) begin
                errors++;
                $display("FAIL match_pulse: bit %0d got %b, expected %b", i, match, e);
            end
            if (match === 1'b1) mask[i] = 1'b1;
        end
    endtask

    task automatic finish_check(input int exp_cnt);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || match_cnt !== exp_cnt[7:0]) begin
            errors++;
            $display("FAIL done_state: got done=%b busy=%b cnt=%0d, expected 1/0/%0d",
                     done, busy, match_cnt, exp_cnt);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || match_cnt !== exp_cnt[7:0]) begin
            errors++;
            $display("FAIL after_done: got done=%b busy=%b cnt=%0d, expected 0/0/%0d",
                     done, busy, match_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 1'b0 || bit_ready !== 1'b0 || match !== 1'b0 || done !== 1'b0
            || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b rdy=%b match=%b done=%b cnt=%0d, expected all 0",
                     busy, bit_ready, match, done, match_cnt);
        end
        rst = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_basic(input bit gap);
        logic [31:0] mask;
        start_frame(8'd12);
        send_bits(STREAM_A, 12, gap, mask);
        checks++;
        if (mask !== 32'h420) begin
            errors++;
            $display("FAIL basic_positions: got mask %0h, expected 420", mask);
        end
`ifdef SEQDET_FIRST_HIT_EN
        checks++;
        if (first_hit !== 8'd5 || hit_seen !== 1'b1) begin
            errors++;
            $display("FAIL first_hit: got %0d/%b, expected 5/1", first_hit, hit_seen);
        end
`endif
        finish_check(2);
    endtask

    task automatic test_overlap();
        logic [31:0] mask;
        cfg(4'b1101, 1'b1);
        start_frame(8'd7);
        send_bits(STREAM_B, 7, 1'b0, mask);
        finish_check(2);
        cfg(4'b1101, 1'b0);
        start_frame(8'd7);
        send_bits(STREAM_B, 7, 1'b0, mask);
        finish_check(1);
    endtask

    task automatic test_saturate();
        logic [31:0] mask;
        cfg(4'b0000, 1'b1);
        start_frame(8'd8);
        send_bits(32'h0, 8, 1'b0, mask);
        checks++;
        if (match_cnt2 !== 2'd3 || done2 !== 1'b1 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL saturate_cnt: got cnt=%0d done=%b busy=%b, expected 3/1/0",
                     match_cnt2, done2, busy2);
        end
        finish_check(5);
        checks++;
        if (match2 !== 1'b0 || bit_ready2 !== 1'b0 || match_cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL saturate_idle: got match=%b rdy=%b cnt=%0d, expected 0/0/3",
                     match2, bit_ready2, match_cnt2);
        end
        cfg(4'b1101, 1'b1);
    endtask

    task automatic test_zero_len();
        start = 1'b1; frame_len = 8'd0;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || match_cnt !== 8'd0) begin
            errors++;
            $display("FAIL zero_len_done: got done=%b busy=%b cnt=%0d, expected 1/0/0",
                     done, busy, match_cnt);
        end
`ifdef SEQDET_FIRST_HIT_EN
        checks++;
        if (hit_seen !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_hit_seen: got %b, expected 0", hit_seen);
        end
`endif
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_after: got done=%b busy=%b, expected 0/0", done, busy);
        end
    endtask

    task automatic test_ignored();
        logic [31:0] mask;
        start_frame(8'd12);
        send_bits(STREAM_A >> 9, 3, 1'b0, mask);
        cfg_we = 1'b1; cfg_pattern = 4'b0000; cfg_overlap = 1'b0;
        start = 1'b1; frame_len = 8'd3;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL run_ignore: got busy=%b done=%b, expected 1/0", busy, done);
        end
        send_bits(STREAM_A & 32'h1FF, 9, 1'b0, mask);
        finish_check(2);
    endtask

    task automatic test_abort();
        logic [31:0] mask;
        abort = 1'b1;
        start_frame(8'd12);
        abort = 1'b0;
        send_bits(STREAM_A >> 7, 5, 1'b0, mask);
        abort = 1'b1;
        send_bits(32'h1, 1, 1'b0, mask);
        abort = 1'b0;
        checks++;
        if (mask !== 32'h1 || busy !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd1) begin
            errors++;
            $display("FAIL abort_same_edge: got match=%0h busy=%b done=%b cnt=%0d, expected 1/0/0/1",
                     mask, busy, done, match_cnt);
        end
        start_frame(8'd12);
        send_bits(STREAM_A >> 6, 6, 1'b0, mask);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd1) begin
                errors++;
                $display("FAIL abort_after6: cycle %0d got busy=%b done=%b cnt=%0d, expected 0/0/1",
                         k, busy, done, match_cnt);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] mask;
        start_frame(8'd12);
        send_bits(STREAM_A >> 6, 6, 1'b0, mask);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || match_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_mid: cycle %0d got busy=%b done=%b cnt=%0d, expected 0/0/0",
                         k, busy, done, match_cnt);
            end
            tick();
        end
        start_frame(8'd7);
        send_bits(STREAM_B, 7, 1'b0, mask);
        finish_check(2);
    endtask

    initial begin
        test_reset();
        test_basic(1'b0);
        test_overlap();
        test_saturate();
        test_zero_len();
        test_ignored();
        test_abort();
        test_reset_mid();
        test_basic(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
